decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL: instr_d / pc_d / pc_plus_4_d  input  32 each  instruction, PC and PC+4 from fetch, valid in decode cycle.
REQ-004 SHALL: stall_e  input  1  hold all ID/EX outputs.
REQ-005 SHALL: flush_e  input  1  load a bubble into ID/EX.
REQ-006 SHALL: reg_write_w  input  1  writeback enable.
REQ-007 SHALL: rd_w  input  5  writeback register index.
REQ-008 SHALL: result_w  input  32  writeback data.
REQ-009 SHALL: rs1_d / rs2_d  output  5 each  combinational instr_d[19:15] / instr_d[24:20], for the hazard unit.
REQ-010 SHALL: rd1_e / rd2_e / imm_e / pc_e / pc_plus_4_e  output  32 each  registered operands, immediate, PC values.
REQ-011 SHALL: rs1_e / rs2_e / rd_e  output  5 each  registered register indices.
REQ-012 SHALL: reg_write_e / mem_write_e / branch_e / jump_e / alu_src_e  output  1 each  registered controls.
REQ-013 SHALL: result_src_e  output  2  00 ALU, 01 memory, 10 PC+4.
REQ-014 SHALL: alu_control_e  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.

Function
REQ-015 SHALL: 32x32 register file; two combinational read ports (rs1_d, rs2_d), one write port written at rising edge when reg_write_w=1 and rd_w!=0.
REQ-016 SHALL: reads of x0 return 0; writes to x0 are discarded.
REQ-017 SHALL: same-cycle bypass: if reg_write_w=1, rd_w!=0 and rd_w equals a read index, that port returns result_w.
REQ-018 SHALL: decode by opcode instr_d[6:0]. lw 0000011: reg_write, alu_src, result_src=01, add, I-imm.
REQ-019 SHALL: sw 0100011: mem_write, alu_src, add, S-imm.
REQ-020 SHALL: R-type 0110011: reg_write; funct3/funct7[5]: 000/0 add, 000/1 sub, 111 and, 110 or, 010 slt.
REQ-021 SHALL: I-ALU 0010011: reg_write, alu_src, I-imm; funct3 000 add, 111 and, 110 or, 010 slt.
REQ-022 SHALL: beq 1100011: branch, sub, B-imm.
REQ-023 SHALL: jal 1101111: reg_write, jump, result_src=10, J-imm.
REQ-024 SHALL: unlisted opcode or funct3: all control outputs 0, alu_control 000 (treated as NOP).
REQ-025 SHALL: immediates sign-extended from instr_d[31]; B/J immediates have bit0=0; non-immediate formats produce imm=0.
REQ-026 SHALL: ID/EX register latency one cycle: decode of instr_d in cycle N visible on *_e after edge N+1.
REQ-027 SHALL: priority per edge: reset > flush_e > stall_e > load.
REQ-028 SHALL: flush_e=1 clears every *_e output to 0, even when stall_e=1.
REQ-029 SHALL: stall_e=1 with flush_e=0 holds every *_e output unchanged; register-file writes still occur.
REQ-030 SHALL: rd1_e/rd2_e capture bypassed values (REQ-017) when a writeback coincides with decode.

Reset
REQ-031 SHALL: reset=1 clears all 32 registers and every *_e output to 0 at the next rising edge, overriding stall_e, flush_e and writeback.
REQ-032 SHALL: reset asserted mid-operation discards the in-flight ID/EX content; first post-reset load occurs at the first edge with reset=0.

Verification
REQ-033 SHALL: write x5=0x0000_00AA, then instr_d=add x7,x5,x5 (0x005283B3) -> next cycle rd1_e=rd2_e=0xAA, rd_e=7, reg_write_e=1, alu_control_e=000.
REQ-034 SHALL: reg_write_w=1, rd_w=3, result_w=0x1234 while decoding addi x4,x3,-1 (0xFFF18213) -> rd1_e=0x1234, imm_e=0xFFFFFFFF, alu_src_e=1.
REQ-035 SHALL: write x0=0xDEAD, then decode add x1,x0,x0 -> rd1_e=rd2_e=0.
REQ-036 SHALL: beq with B-imm -8 (0xFE000CE3) -> branch_e=1, alu_control_e=001, imm_e=0xFFFFFFF8; jal x1,+16 (0x010000EF) -> jump_e=1, result_src_e=10, imm_e=0x10.
REQ-037 SHALL: stall_e=1 for two cycles -> *_e held; flush_e=1 and stall_e=1 together -> all *_e=0.
REQ-038 SHALL: reset pulse after loading registers -> every *_e=0 and reads of x1..x31 return 0.

Source files
------------

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch/writeback inputs and ID/EX outputs of the decode stage
interface decode_stage_if;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus_4_d;
  logic        stall_e;
  logic        flush_e;
  logic        reg_write_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic [4:0]  rs1_d;
  logic [4:0]  rs2_d;
  logic [31:0] rd1_e;
  logic [31:0] rd2_e;
  logic [31:0] imm_e;
  logic [31:0] pc_e;
  logic [31:0] pc_plus_4_e;
  logic [4:0]  rs1_e;
  logic [4:0]  rs2_e;
  logic [4:0]  rd_e;
  logic        reg_write_e;
  logic        mem_write_e;
  logic        branch_e;
  logic        jump_e;
  logic        alu_src_e;
  logic [1:0]  result_src_e;
  logic [2:0]  alu_control_e;

  modport master (
    output instr_d, pc_d, pc_plus_4_d, stall_e, flush_e, reg_write_w, rd_w, result_w,
    input  rs1_d, rs2_d, rd1_e, rd2_e, imm_e, pc_e, pc_plus_4_e, rs1_e, rs2_e, rd_e,
    input  reg_write_e, mem_write_e, branch_e, jump_e, alu_src_e, result_src_e, alu_control_e
  );

  modport slave (
    input  instr_d, pc_d, pc_plus_4_d, stall_e, flush_e, reg_write_w, rd_w, result_w,
    output rs1_d, rs2_d, rd1_e, rd2_e, imm_e, pc_e, pc_plus_4_e, rs1_e, rs2_e, rd_e,
    output reg_write_e, mem_write_e, branch_e, jump_e, alu_src_e, result_src_e, alu_control_e
  );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32 subset decode: register file, control decode, ID/EX register
module decode_stage (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus
);
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [31:0] regs [32];
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        wb_en;
  logic [31:0] rd1_d, rd2_d, imm_d;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic        reg_write_d, mem_write_d, branch_d, jump_d, alu_src_d;
  logic [1:0]  result_src_d;
  logic [2:0]  alu_control_d;

  assign instr     = bus.instr_d;
  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign bus.rs1_d = instr[19:15];
  assign bus.rs2_d = instr[24:20];
  assign wb_en     = bus.reg_write_w && (bus.rd_w != 5'd0);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[bus.rd_w] <= bus.result_w;
    end
  end

  // A writeback landing in the decode cycle is forwarded so ID/EX never captures stale data.
  always_comb begin
    rd1_d = regs[bus.rs1_d];
    if (bus.rs1_d == 5'd0) rd1_d = '0;
    else if (wb_en && (bus.rd_w == bus.rs1_d)) rd1_d = bus.result_w;
    rd2_d = regs[bus.rs2_d];
    if (bus.rs2_d == 5'd0) rd2_d = '0;
    else if (wb_en && (bus.rd_w == bus.rs2_d)) rd2_d = bus.result_w;
  end

  always_comb begin
    reg_write_d   = 1'b0;
    mem_write_d   = 1'b0;
    branch_d      = 1'b0;
    jump_d        = 1'b0;
    alu_src_d     = 1'b0;
    result_src_d  = 2'b00;
    alu_control_d = ALU_ADD;
    imm_d         = '0;
    case (opcode)
      OP_LW: begin
        reg_write_d  = 1'b1;
        alu_src_d    = 1'b1;
        result_src_d = 2'b01;
        imm_d        = imm_i;
      end
      OP_SW: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_d       = imm_s;
      end
      OP_R: begin
        reg_write_d = 1'b1;
        case (funct3)
          3'b000:  alu_control_d = instr[30] ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control_d = ALU_AND;
          3'b110:  alu_control_d = ALU_OR;
          3'b010:  alu_control_d = ALU_SLT;
          default: reg_write_d = 1'b0;
        endcase
      end
      OP_I: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_d       = imm_i;
        case (funct3)
          3'b000:  alu_control_d = ALU_ADD;
          3'b111:  alu_control_d = ALU_AND;
          3'b110:  alu_control_d = ALU_OR;
          3'b010:  alu_control_d = ALU_SLT;
          default: begin
            reg_write_d = 1'b0;
            alu_src_d   = 1'b0;
            imm_d       = '0;
          end
        endcase
      end
      OP_BEQ: begin
        branch_d      = 1'b1;
        alu_control_d = ALU_SUB;
        imm_d         = imm_b;
      end
      OP_JAL: begin
        reg_write_d  = 1'b1;
        jump_d       = 1'b1;
        result_src_d = 2'b10;
        imm_d        = imm_j;
      end
      default: ;
    endcase
  end

  // Reset and flush both produce a bubble; flush also wins over stall.
  always_ff @(posedge clk) begin
    if (reset || bus.flush_e) begin
      bus.rd1_e         <= '0;
      bus.rd2_e         <= '0;
      bus.imm_e         <= '0;
      bus.pc_e          <= '0;
      bus.pc_plus_4_e   <= '0;
      bus.rs1_e         <= '0;
      bus.rs2_e         <= '0;
      bus.rd_e          <= '0;
      bus.reg_write_e   <= 1'b0;
      bus.mem_write_e   <= 1'b0;
      bus.branch_e      <= 1'b0;
      bus.jump_e        <= 1'b0;
      bus.alu_src_e     <= 1'b0;
      bus.result_src_e  <= 2'b00;
      bus.alu_control_e <= 3'b000;
    end else if (!bus.stall_e) begin
      bus.rd1_e         <= rd1_d;
      bus.rd2_e         <= rd2_d;
      bus.imm_e         <= imm_d;
      bus.pc_e          <= bus.pc_d;
      bus.pc_plus_4_e   <= bus.pc_plus_4_d;
      bus.rs1_e         <= bus.rs1_d;
      bus.rs2_e         <= bus.rs2_d;
      bus.rd_e          <= instr[11:7];
      bus.reg_write_e   <= reg_write_d;
      bus.mem_write_e   <= mem_write_d;
      bus.branch_e      <= branch_d;
      bus.jump_e        <= jump_d;
      bus.alu_src_e     <= alu_src_d;
      bus.result_src_e  <= result_src_d;
      bus.alu_control_e <= alu_control_d;
    end
  end
endmodule
